pipe_tx_block_framer: RTL and testbench
=======================================

// Module: pipe_tx_block_framer
// PURPOSE
//  MAC-side, per-lane 128b/130b transmit framer that drives the TX data signals of one
//  PIPE lane (TxData, TxDataValid, TxStartBlock, TxSyncHeader) at 8/16 GT/s-class rates.
//  Accepts whole 128-bit blocks plus a 2-bit sync header from the lane's block source
//  over valid/ready and serialises each block onto the PIPE data width.
//  Inserts the mandatory TxDataValid gearbox stall cycle; one instance per lane.
// PARAMETERS
//  DATA_WIDTH  32  per-lane PIPE data width in bits; legal 8, 16, 32 (elaboration error otherwise)
// PORTS
//  PCLK          in   1           PIPE clock; the only clock
//  Reset         in   1           synchronous, active-high reset
//  enable        in   1           1 = 128b/130b framing active; 0 = flush and idle
//  blk_valid     in   1           block source has a block
//  blk_ready     out  1           framer accepts the block this cycle
//  blk_data      in   128         block payload, symbol 0 in [7:0]
//  blk_sync      in   2           sync header (2'b10 data, 2'b01 ordered set)
//  TxData        out  DATA_WIDTH  lane data to PHY
//  TxDataValid   out  1           0 on stall/idle cycles
//  TxStartBlock  out  1           1 on the first word of a block
//  TxSyncHeader  out  2           header of the block in flight
//  underrun_err  out  1           1-cycle pulse: no block at a block boundary while sending
// BEHAVIOUR
//  - Reset (sampled on PCLK edge): every output 0, state IDLE, counters 0, block register cleared.
//  - N = 128/DATA_WIDTH words per block; S = DATA_WIDTH/2 blocks per stall period.
//  - All PIPE outputs are registered; word k = blk_data[k*DATA_WIDTH +: DATA_WIDTH].
//  - States: IDLE (no block in flight), SEND (word_cnt = index of word on TxData),
//    STALL (one cycle, TxDataValid=0, TxStartBlock=0, TxData holds the last word).
//  - blk_ready = enable & (IDLE | STALL | (SEND & word_cnt==N-1 & !stall_due)); combinational,
//    with no dependence on blk_valid.
//  - Handshake at cycle t -> word 0 on TxData at t+1, TxStartBlock=1, TxDataValid=1,
//    TxSyncHeader=blk_sync; header held on TxSyncHeader for the whole block.
//  - Back-to-back blocks produce no gap except the stall. blk_cnt counts completed
//    blocks 0..S-1. stall_due = (blk_cnt==S-1) at the last word; the next cycle is STALL
//    and blk_cnt wraps to 0.
//  - STALL is taken even if blk_valid=1; the next block is accepted during STALL.
//  - At a block boundary (SEND last word, no stall due) with blk_valid=0: go IDLE, TxDataValid=0,
//    TxStartBlock=0, TxData=0, underrun_err pulses once. blk_cnt is retained; the cadence
//    resumes with the next block. Further idle cycles do not pulse.
//  - IDLE after reset or enable rise is not an underrun.
//  - enable=0 (any state, mid-block included): next cycle outputs as at reset, state IDLE,
//    word_cnt and blk_cnt cleared, blk_ready=0, the in-flight block is discarded.
//    Enable rising restarts the cadence at blk_cnt=0.
//  - Reset mid-operation overrides enable and the handshake; a block offered that cycle
//    is not accepted.
//  - Counter widths: word_cnt = $clog2(N) bits (N=4..16); blk_cnt = $clog2(S) bits (S=4..16).
// STRUCTURE
//  - Shared package pipe_pkg: PIPE_BLOCK_BITS=128, SYNC_HDR_DATA=2'b10,
//    SYNC_HDR_OS=2'b01, and the framer state enum typedef.
//  - One natural sub-module: pipe_gearbox_stall_ctr (blk_cnt, stall_due, wrap, clear on !enable).
//  - Top holds the FSM, the 128-bit block register, the word mux and the output registers.
// TESTING
//  - W=32, 16 back-to-back blocks -> 64 valid cycles, TxStartBlock at offsets 0,4,..,60,
//    then exactly 1 cycle TxDataValid=0; 17th block starts at offset 65.
//  - W=8, continuous blocks -> 16 words per block, stall after every 4th block (every 65 cycles).
//  - blk_data=128'h0F0E..0100, blk_sync=2'b01, W=32 -> TxData 32'h03020100, ..07060504, ..0B0A0908,
//    ..0F0E0D0C; TxSyncHeader=2'b01 all 4 cycles.
//  - blk_valid dropped after block 2 of 8 for 5 cycles -> one underrun_err pulse, 5 idle cycles;
//    stall still follows the 8th completed block (W=16).
//  - enable=0 at word 1 of a block -> next cycle all PIPE outputs 0, blk_ready=0.
//    Re-enable -> fresh block, stall after S blocks.
//  - Reset asserted at word 2 with blk_valid=1 -> outputs 0 next edge, no handshake;
//    after release, the first block appears 1 cycle after acceptance.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared PIPE definitions: 128b/130b block size, sync header codes and framer state encoding.
package pipe_pkg;

  localparam int unsigned PIPE_BLOCK_BITS = 128;
  localparam logic [1:0]  SYNC_HDR_DATA   = 2'b10;
  localparam logic [1:0]  SYNC_HDR_OS     = 2'b01;

  typedef enum logic [1:0] {
    FR_IDLE  = 2'd0,
    FR_SEND  = 2'd1,
    FR_STALL = 2'd2
  } framer_state_e;

endpackage

// File: rtl/pipe_gearbox_stall_ctr.sv
// Counts completed blocks and flags the block whose completion must be followed by the
// gearbox stall cycle; wraps at BLOCKS_PER_STALL and clears while framing is disabled.
module pipe_gearbox_stall_ctr #(
  parameter int unsigned BLOCKS_PER_STALL = 16,
  parameter int unsigned CNT_W            = $clog2(BLOCKS_PER_STALL)
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic blk_done,
  output logic stall_due_c
);

  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             at_wrap;

  assign at_wrap     = (blk_cnt_q == CNT_W'(BLOCKS_PER_STALL - 1));
  assign stall_due_c = blk_done & at_wrap;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (!enable) begin
      blk_cnt_d = '0;
    end else if (blk_done) begin
      blk_cnt_d = at_wrap ? '0 : blk_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) blk_cnt_q <= '0;
    else     blk_cnt_q <= blk_cnt_d;
  end

endmodule

// File: rtl/pipe_tx_block_framer.sv
// Per-lane 128b/130b transmit framer: takes whole blocks over valid/ready, serialises them
// onto the PIPE data width and inserts the periodic TxDataValid gearbox stall.
module pipe_tx_block_framer
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       PCLK,
  input  logic                       Reset,
  input  logic                       enable,
  input  logic                       blk_valid,
  output logic                       blk_ready,
  input  logic [PIPE_BLOCK_BITS-1:0] blk_data,
  input  logic [1:0]                 blk_sync,
  output logic [DATA_WIDTH-1:0]      TxData,
  output logic                       TxDataValid,
  output logic                       TxStartBlock,
  output logic [1:0]                 TxSyncHeader,
  output logic                       underrun_err
);

  localparam int unsigned N      = PIPE_BLOCK_BITS / DATA_WIDTH;
  localparam int unsigned S      = DATA_WIDTH / 2;
  localparam int unsigned WCNT_W = $clog2(N);

  if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32)) begin : g_bad_width
    $error("pipe_tx_block_framer: DATA_WIDTH must be 8, 16 or 32");
  end

  framer_state_e              state_q, state_d;
  logic [WCNT_W-1:0]          word_cnt_q, word_cnt_d, next_word;
  logic [PIPE_BLOCK_BITS-1:0] blk_q, blk_d;
  logic [DATA_WIDTH-1:0]      tx_data_q, tx_data_d;
  logic                       tx_valid_q, tx_valid_d;
  logic                       tx_start_q, tx_start_d;
  logic [1:0]                 tx_sync_q, tx_sync_d;
  logic                       underrun_q, underrun_d;
  logic                       last_word, blk_done, stall_due, accept;

  assign last_word = (word_cnt_q == WCNT_W'(N - 1));
  assign next_word = word_cnt_q + WCNT_W'(1);
  assign blk_done  = enable & (state_q == FR_SEND) & last_word;

  pipe_gearbox_stall_ctr #(
    .BLOCKS_PER_STALL(S)
  ) u_stall_ctr (
    .clk        (PCLK),
    .rst        (Reset),
    .enable     (enable),
    .blk_done   (blk_done),
    .stall_due_c(stall_due)
  );

  // Reset gating keeps a block offered during reset from being counted as taken.
  assign blk_ready = enable & ~Reset &
                     ((state_q == FR_IDLE) | (state_q == FR_STALL) |
                      ((state_q == FR_SEND) & last_word & ~stall_due));
  assign accept    = blk_valid & blk_ready;

  always_ff @(posedge PCLK) begin
    if (Reset) state_q <= FR_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = FR_IDLE;
    end else if (accept) begin
      state_d = FR_SEND;
    end else begin
      case (state_q)
        FR_SEND:  if (last_word) state_d = stall_due ? FR_STALL : FR_IDLE;
        FR_STALL: state_d = FR_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    blk_d      = blk_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    tx_start_d = 1'b0;
    tx_sync_d  = tx_sync_q;
    underrun_d = 1'b0;
    if (!enable) begin
      word_cnt_d = '0;
      blk_d      = '0;
      tx_data_d  = '0;
      tx_sync_d  = 2'b00;
    end else if (accept) begin
      word_cnt_d = '0;
      blk_d      = blk_data;
      tx_data_d  = blk_data[DATA_WIDTH-1:0];
      tx_valid_d = 1'b1;
      tx_start_d = 1'b1;
      tx_sync_d  = blk_sync;
    end else if (state_q == FR_SEND && !last_word) begin
      word_cnt_d = next_word;
      tx_data_d  = DATA_WIDTH'(blk_q >> (32'(next_word) * DATA_WIDTH));
      tx_valid_d = 1'b1;
    end else if (state_q == FR_SEND && stall_due) begin
      // Stall cycle: TxData and header hold the last word of the finished block.
      word_cnt_d = word_cnt_q;
    end else begin
      underrun_d = (state_q == FR_SEND);
      word_cnt_d = '0;
      tx_data_d  = '0;
      tx_sync_d  = 2'b00;
    end
  end

  always_ff @(posedge PCLK) begin
    if (Reset) begin
      word_cnt_q <= '0;
      blk_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_sync_q  <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      blk_q      <= blk_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_start_q <= tx_start_d;
      tx_sync_q  <= tx_sync_d;
      underrun_q <= underrun_d;
    end
  end

  assign TxData       = tx_data_q;
  assign TxDataValid  = tx_valid_q;
  assign TxStartBlock = tx_start_q;
  assign TxSyncHeader = tx_sync_q;
  assign underrun_err = underrun_q;

endmodule

// File: tb/tb_pipe_tx_block_framer.sv
// Scoreboard bench for pipe_tx_block_framer at DATA_WIDTH 8, 16 and 32 running side by side.
module tb_pipe_tx_block_framer;
  import pipe_pkg::*;

  logic PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sync;
    logic        start;
    int          gap;
  } exp_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Block i carries byte b = 16*i + b (mod 256), so block 0 is 128'h0F0E..0100.
  function automatic logic [127:0] blk_pat(input int i);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[b*8 +: 8] = 8'(16 * i + b);
    return r;
  endfunction

  function automatic logic [31:0] exp_word(input int i, input int k, input int w);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < w / 8; j++) r[j*8 +: 8] = 8'(16 * i + k * (w / 8) + j);
    return r;
  endfunction

  function automatic logic [1:0] sync_of(input int i);
    return (i % 2 == 1) ? SYNC_HDR_DATA : SYNC_HDR_OS;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_w
    localparam int W = 8 << g;
    localparam int N = 128 / W;
    localparam int S = W / 2;

    logic           Reset, enable, blk_valid, blk_ready;
    logic [127:0]   blk_data;
    logic [1:0]     blk_sync;
    logic [W-1:0]   TxData;
    logic           TxDataValid, TxStartBlock;
    logic [1:0]     TxSyncHeader;
    logic           underrun_err;
    logic           done_g = 1'b0;
    exp_t           q[$];
    int             ur_cnt = 0;
    int             gap = 0;
    int             bid = 0;

    pipe_tx_block_framer #(.DATA_WIDTH(W)) dut (
      .PCLK        (PCLK),
      .Reset       (Reset),
      .enable      (enable),
      .blk_valid   (blk_valid),
      .blk_ready   (blk_ready),
      .blk_data    (blk_data),
      .blk_sync    (blk_sync),
      .TxData      (TxData),
      .TxDataValid (TxDataValid),
      .TxStartBlock(TxStartBlock),
      .TxSyncHeader(TxSyncHeader),
      .underrun_err(underrun_err)
    );

    // Monitor: pops one expectation per valid word; gap = invalid cycles since previous word.
    always @(negedge PCLK) begin : mon
      exp_t e;
      if (underrun_err === 1'b1) ur_cnt++;
      if (TxDataValid === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL w%0d_unexpected_word: got 0x%0h expected no word", W, TxData);
        end else begin
          e = q.pop_front();
          check($sformatf("w%0d_data", W), 32'(TxData), e.data);
          check($sformatf("w%0d_start", W), 32'(TxStartBlock), 32'(e.start));
          check($sformatf("w%0d_sync", W), 32'(TxSyncHeader), 32'(e.sync));
          if (e.gap >= 0) check($sformatf("w%0d_gap", W), 32'(gap), 32'(e.gap));
        end
        gap = 0;
      end else begin
        gap++;
      end
    end

    task automatic send_block(input int nwords, input int gap_exp);
      exp_t e;
      int   n;
      blk_data  = blk_pat(bid);
      blk_sync  = sync_of(bid);
      blk_valid = 1'b1;
      for (int k = 0; k < nwords; k++) begin
        e.data  = exp_word(bid, k, W);
        e.sync  = sync_of(bid);
        e.start = (k == 0);
        e.gap   = (k == 0) ? gap_exp : 0;
        q.push_back(e);
      end
      bid++;
      #1;
      n = 0;
      while (!blk_ready && n < 100) begin
        @(negedge PCLK);
        n++;
      end
      if (n >= 100) begin
        total++;
        bad++;
        $display("FAIL w%0d_ready_timeout: got blk_ready=0 expected 1 within 100 cycles", W);
      end
      @(negedge PCLK);
      blk_valid = 1'b0;
    endtask

    task automatic check_idle(input string name, input logic with_ready);
      check($sformatf("w%0d_%s_data", W, name), 32'(TxData), 32'd0);
      check($sformatf("w%0d_%s_valid", W, name), 32'(TxDataValid), 32'd0);
      check($sformatf("w%0d_%s_start", W, name), 32'(TxStartBlock), 32'd0);
      check($sformatf("w%0d_%s_sync", W, name), 32'(TxSyncHeader), 32'd0);
      check($sformatf("w%0d_%s_underrun", W, name), 32'(underrun_err), 32'd0);
      if (with_ready) check($sformatf("w%0d_%s_ready", W, name), 32'(blk_ready), 32'd0);
    endtask

    initial begin : drv
      Reset = 1'b1; enable = 1'b0; blk_valid = 1'b0; blk_data = '0; blk_sync = 2'b00;
      repeat (3) @(negedge PCLK);
      check_idle("reset", 1'b1);
      Reset = 1'b0;
      @(negedge PCLK);
      enable = 1'b1;
      #1;
      check($sformatf("w%0d_ready_idle", W), 32'(blk_ready), 32'd1);

      // Continuous stream: stall after every S-th block, ending in an underrun.
      for (int i = 0; i < 2 * S + 1; i++) send_block(N, (i == 0) ? -1 : ((i % S == 0) ? 1 : 0));
      repeat (N + 3) @(negedge PCLK);
      check($sformatf("w%0d_underrun_stream", W), 32'(ur_cnt), 32'd1);

      // Disable at word 1 of a block, then re-enable for a fresh cadence.
      send_block(2, -1);
      @(negedge PCLK);
      enable = 1'b0;
      @(negedge PCLK);
      check_idle("disable", 1'b1);
      enable = 1'b1;
      for (int i = 0; i < S + 1; i++) send_block(N, (i == 0) ? -1 : ((i == S) ? 1 : 0));
      repeat (N + 3) @(negedge PCLK);
      check($sformatf("w%0d_underrun_reenable", W), 32'(ur_cnt), 32'd2);

      // Source starves after block 2 for 5 idle cycles; stall still after S completed blocks.
      enable = 1'b0;
      @(negedge PCLK);
      enable = 1'b1;
      send_block(N, -1);
      send_block(N, 0);
      repeat (N + 4) @(negedge PCLK);
      check($sformatf("w%0d_underrun_gap", W), 32'(ur_cnt), 32'd3);
      check($sformatf("w%0d_gap_idle_valid", W), 32'(TxDataValid), 32'd0);
      send_block(N, 5);
      for (int i = 3; i <= S; i++) send_block(N, (i == S) ? 1 : 0);
      repeat (N + 3) @(negedge PCLK);
      check($sformatf("w%0d_underrun_gap_end", W), 32'(ur_cnt), 32'd4);

      // Reset at word 2 while a block is offered: nothing accepted during reset.
      send_block(3, -1);
      repeat (2) @(negedge PCLK);
      Reset = 1'b1; blk_valid = 1'b1; blk_data = blk_pat(99); blk_sync = SYNC_HDR_DATA;
      @(negedge PCLK);
      check_idle("midreset", 1'b0);
      Reset = 1'b0;
      send_block(N, 1);
      repeat (N + 3) @(negedge PCLK);
      check($sformatf("w%0d_underrun_after_reset", W), 32'(ur_cnt), 32'd5);
      check($sformatf("w%0d_queue_drained", W), 32'(q.size()), 32'd0);
      done_g = 1'b1;
    end
  end

  initial begin : main
    for (int c = 0; c < 30000; c++) begin
      if (g_w[0].done_g && g_w[1].done_g && g_w[2].done_g) break;
      @(negedge PCLK);
    end
    if (!(g_w[0].done_g && g_w[1].done_g && g_w[2].done_g)) begin
      total++;
      bad++;
      $display("FAIL timeout: got unfinished drivers expected all done within 30000 cycles");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
